sample_window_gen: RTL and testbench
====================================

# sample_window_gen

Upstream feeder for the single-channel short register FIFO stage. On a start pulse it waits a programmable delay, then opens a `sel` window of a programmable number of cycles. During that window it forwards registered source samples on `din`, zero-filled outside the window. The downstream FIFO stage consumes `sel`/`din` directly, and the shared `FRST` aborts both blocks together.

## Interface
- `DW`, 27, sample width
- `CW`, 13, width of delay/length configuration and internal counter
- `CLK`  in  1  single clock, all logic on posedge
- `RST_X`  in  1  asynchronous active-low reset
- `FRST`  in  1  frame reset, synchronous to CLK posedge, highest priority
- `start`  in  1  one-cycle request to open a window
- `cfg_dly`  in  CW  cycles from start sample to first `sel` cycle; latched at accepted start
- `cfg_len`  in  CW  window length in cycles; latched at accepted start
- `src_din`  in  DW  source sample stream, valid every cycle
- `sel`  out  1  window active, registered
- `din`  out  DW  registered sample, zero when `sel`=0
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse after window closes
- `drop`  out  1  sticky: start arrived while busy; cleared by FRST

## Operation
- Reset (`RST_X`=0): state IDLE, counter 0, latched cfg 0.
- Reset output values: `sel`=0, `din`=0, `busy`=0, `done`=0, `drop`=0.
- States: IDLE, WAIT, RUN, DONE.
- IDLE, start=1: latch cfg_dly/cfg_len. Go to WAIT if dly>0, else RUN if len>0, else DONE.
- WAIT: counts dly cycles, then goes to RUN if len>0, else DONE.
- RUN: counts len cycles, then goes to DONE.
- DONE: one cycle, then IDLE. A start seen in DONE is a drop, not accepted.
- `sel` = (state==RUN).
- `din` register loads `src_din` when the next state is RUN, else loads 0.
- start while state≠IDLE: ignored, `drop` set to 1 and held.
- FRST=1 at an edge:
  - state → IDLE; `sel`, `din`, `done` → 0; counter cleared.
  - A start in the same cycle is ignored and does not set drop.
  - `drop` is cleared.
- Counter is an unsigned CW-bit down-counter. Max dly/len = 2^CW−1. No wrap: the counter reloads on every state entry.
- cfg inputs are don't-care except in the cycle where start is accepted.

## Timing
- Start accepted at edge t.
- `busy` high from after edge t until after edge t+dly+len+1.
- `sel` high for exactly len cycles: after edges t+dly … t+dly+len−1.
- `din` during the k-th sel cycle (k=0..len−1) equals `src_din` sampled at edge t+dly+k. `din`/`sel` latency from `src_din` is 1 cycle.
- `done` high for the single cycle after edge t+dly+len.
- Earliest next accepted start: edge t+dly+len+1 (state IDLE).
- dly=0, len=0: DONE after edge t, `sel` never asserted.
- FRST during RUN: `sel` low after that edge, no `done` pulse.

## Structure
- Shared package constants: state encoding (IDLE=2'd0, WAIT=2'd1, RUN=2'd2, DONE=2'd3).
- Package typedef: `cnt_t` of CW bits.
- Single flat module; no sub-module. The counter is inline with the FSM.
- Output `sel`/`din` stay registered so the downstream stage sees glitch-free inputs.

## Test plan
- Reset, then idle 10 cycles -> `sel`=0, `din`=0, `busy`=0, `done`=0, `drop`=0 throughout.
- start at edge 5, dly=3, len=4, `src_din`=cycle index -> `sel` high after edges 8..11, `din`=8,9,10,11, `done` high after edge 12, `busy` low after edge 13.
- start with dly=0, len=0 -> `done` pulse after the start edge, `sel` never high, `busy` high exactly 1 cycle.
- Second start 2 cycles into a dly=2, len=5 window -> window unchanged, `drop`=1 held; later FRST -> `drop`=0.
- FRST asserted during the 3rd of 6 RUN cycles -> `sel`/`din` 0 after that edge, no `done`, `busy`=0; a start 1 cycle later is accepted normally.
- start with dly=8191, len=1 -> exactly one `sel` cycle, 8191 cycles after the start edge; no counter wrap.

Source files
------------

// File: rtl/sample_window_gen_pkg.sv
// Shared constants and types for the sample window generator.
package sample_window_gen_pkg;

  localparam int DW = 27;
  localparam int CW = 13;

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sample_window_gen_if.sv
// Request/config/sample bundle between a controller and the window generator.
interface sample_window_gen_if;
  import sample_window_gen_pkg::*;

  logic          start;
  cnt_t          cfg_dly;
  cnt_t          cfg_len;
  logic [DW-1:0] src_din;
  logic          sel;
  logic [DW-1:0] din;
  logic          busy;
  logic          done;
  logic          drop;

  modport master (
    output start, cfg_dly, cfg_len, src_din,
    input  sel, din, busy, done, drop
  );

  modport slave (
    input  start, cfg_dly, cfg_len, src_din,
    output sel, din, busy, done, drop
  );

endinterface

// File: rtl/sample_window_gen.sv
// Sample window generator: after a start, waits cfg_dly cycles, then opens a
// sel window of cfg_len cycles forwarding registered src_din samples.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start
// ST_WAIT | delay countdown, counter holds remaining delay cycles
// ST_RUN  | sel window open, counter holds remaining window cycles
// ST_DONE | single-cycle completion pulse, starts here are dropped
module sample_window_gen
  import sample_window_gen_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_X,
  input  logic               FRST,
  sample_window_gen_if.slave bus
);

  state_t        state_q, state_d;
  cnt_t          cnt_q, cnt_d;
  cnt_t          len_q, len_d;
  logic [DW-1:0] din_q, din_d;
  logic          drop_q, drop_d;

  // Next-state, counter reload/countdown, drop flag and sample capture.
  // The delay only lives in the counter; the length is held for the
  // WAIT->RUN reload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    drop_d  = drop_q;

    if (FRST) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      drop_d  = 1'b0;
    end else begin
      if (bus.start && (state_q != ST_IDLE)) begin
        drop_d = 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            len_d = bus.cfg_len;
            if (bus.cfg_dly != '0) begin
              state_d = ST_WAIT;
              cnt_d   = bus.cfg_dly;
            end else if (bus.cfg_len != '0) begin
              state_d = ST_RUN;
              cnt_d   = bus.cfg_len;
            end else begin
              state_d = ST_DONE;
              cnt_d   = '0;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == cnt_t'(1)) begin
            if (len_q != '0) begin
              state_d = ST_RUN;
              cnt_d   = len_q;
            end else begin
              state_d = ST_DONE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
        ST_RUN: begin
          if (cnt_q == cnt_t'(1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    din_d = (state_d == ST_RUN) ? bus.src_din : '0;
  end

  // State, counter, latched length, output sample and sticky drop registers.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      din_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      din_q   <= din_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.sel  = (state_q == ST_RUN);
  assign bus.din  = din_q;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.drop = drop_q;

endmodule

// File: tb/tb_sample_window_gen.sv
// Bench for sample_window_gen: directed and random start/FRST sequences
// checked every cycle against a window-schedule reference model.
module tb_sample_window_gen;
  import sample_window_gen_pkg::*;

  logic CLK = 1'b0;
  logic RST_X;
  logic FRST;

  sample_window_gen_if bus ();

  sample_window_gen dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .FRST  (FRST),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  int edge_n  = 0;

  // Model: one accepted window described by its start edge and cfg.
  bit            m_active = 1'b0;
  int            m_t0     = 0;
  int            m_dly    = 0;
  int            m_len    = 0;
  bit            m_drop   = 1'b0;
  logic [DW-1:0] m_src    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
  endtask

  function automatic bit m_busy_after(input int n);
    return m_active && ((n - m_t0) <= (m_dly + m_len));
  endfunction

  task automatic check_outputs();
    int            rel;
    bit            busy_e, sel_e, done_e;
    logic [DW-1:0] din_e;
    rel    = edge_n - m_t0;
    busy_e = m_busy_after(edge_n);
    sel_e  = busy_e && (rel >= m_dly) && (rel < m_dly + m_len);
    done_e = busy_e && (rel == m_dly + m_len);
    din_e  = sel_e ? m_src : '0;
    chk("sel",  32'(bus.sel),  32'(sel_e));
    chk("din",  32'(bus.din),  32'(din_e));
    chk("busy", 32'(bus.busy), 32'(busy_e));
    chk("done", 32'(bus.done), 32'(done_e));
    chk("drop", 32'(bus.drop), 32'(m_drop));
  endtask

  // One clock: drive inputs, advance model at the edge, check at negedge.
  task automatic cycle(input bit st, input int dly, input int len, input bit fr);
    bus.start   = st;
    bus.cfg_dly = cnt_t'(dly);
    bus.cfg_len = cnt_t'(len);
    bus.src_din = DW'($urandom);
    FRST        = fr;
    @(posedge CLK);
    edge_n++;
    if (fr) begin
      m_active = 1'b0;
      m_drop   = 1'b0;
    end else if (st) begin
      if (m_busy_after(edge_n - 1)) begin
        m_drop = 1'b1;
      end else begin
        m_active = 1'b1;
        m_t0     = edge_n;
        m_dly    = dly;
        m_len    = len;
      end
    end
    m_src = bus.src_din;
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      cycle(1'b0, $urandom_range(0, 8191), $urandom_range(0, 8191), 1'b0);
    end
  endtask

  initial begin
    int t_big;
    int sel_cnt;
    int sel_edge;
    int d;

    RST_X       = 1'b0;
    FRST        = 1'b0;
    bus.start   = 1'b0;
    bus.cfg_dly = '0;
    bus.cfg_len = '0;
    bus.src_din = '0;
    repeat (3) @(negedge CLK);
    check_outputs();
    RST_X = 1'b1;

    // Idle after reset.
    idle(10);

    // Basic window dly=3 len=4.
    cycle(1'b1, 3, 4, 1'b0);
    idle(10);

    // Zero delay, zero length: immediate done.
    cycle(1'b1, 0, 0, 1'b0);
    idle(3);

    // Zero delay, nonzero length.
    cycle(1'b1, 0, 3, 1'b0);
    idle(5);

    // Start while busy is dropped; FRST clears drop.
    cycle(1'b1, 2, 5, 1'b0);
    cycle(1'b0, 0, 0, 1'b0);
    cycle(1'b1, 1, 1, 1'b0);
    idle(8);
    cycle(1'b0, 0, 0, 1'b1);
    idle(2);

    // Start during DONE is dropped.
    cycle(1'b1, 1, 1, 1'b0);
    cycle(1'b0, 0, 0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0);
    cycle(1'b1, 2, 2, 1'b0);
    idle(3);
    cycle(1'b0, 0, 0, 1'b1);

    // FRST in 3rd of 6 RUN cycles with a simultaneous start, then a restart.
    d = $urandom_range(1, 4);
    cycle(1'b1, d, 6, 1'b0);
    idle(d + 2);
    cycle(1'b1, 3, 3, 1'b1);
    cycle(1'b1, $urandom_range(0, 3), $urandom_range(1, 4), 1'b0);
    idle(10);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 5), $urandom_range(0, 5),
            ($urandom_range(0, 24) == 0));
    end
    cycle(1'b0, 0, 0, 1'b1);
    idle(2);

    // Maximum delay, single-cycle window.
    cycle(1'b1, 8191, 1, 1'b0);
    t_big    = edge_n;
    sel_cnt  = 0;
    sel_edge = 0;
    for (int i = 0; i < 8196; i++) begin
      cycle(1'b0, 0, 0, 1'b0);
      if (bus.sel === 1'b1) begin
        sel_cnt++;
        sel_edge = edge_n;
      end
    end
    chk("big_sel_count", 32'(sel_cnt), 32'd1);
    chk("big_sel_offset", 32'(sel_edge - t_big), 32'd8191);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
